// File: rtl/fireboy_motion.sv
// -----------------------------------------------------------------------------
// fireboy_motion
// Per-frame motion controller for the Fireboy sprite. All state advances only
// on vga_clk edges where frame_start is high. Horizontal walking and the
// vertical jump/fall FSM update independently in the same tick. Every output
// is a register, so a new value appears the cycle after the tick.
//
// Ports
//   vga_clk      in   1   sole clock, all state on posedge
//   reset_n      in   1   asynchronous active-low reset
//   frame_start  in   1   one-cycle pulse per video frame (frame tick)
//   key_left     in   1   left key held
//   key_right    in   1   right key held
//   key_up       in   1   jump key held (edge-detected on ticks)
//   on_platform  in   1   feet rest on a solid tile
//   FireX        out  10  sprite-centre X
//   FireY        out  10  sprite-centre Y
//   airborne     out  1   high while RISING or FALLING
//   facing_left  out  1   last horizontal direction was left
// -----------------------------------------------------------------------------
module fireboy_motion #(
   parameter int X_START   = 13,
   parameter int Y_START   = 464,
   parameter int X_MIN     = 13,
   parameter int X_MAX     = 626,
   parameter int Y_MIN     = 15,
   parameter int Y_FLOOR   = 464,
   parameter int WALK_STEP = 2,
   parameter int JUMP_VEL  = 10,
   parameter int GRAVITY   = 1,
   parameter int MAX_FALL  = 8
) (
   input  logic       vga_clk,
   input  logic       reset_n,
   input  logic       frame_start,
   input  logic       key_left,
   input  logic       key_right,
   input  logic       key_up,
   input  logic       on_platform,
   output logic [9:0] FireX,
   output logic [9:0] FireY,
   output logic       airborne,
   output logic       facing_left
);

   typedef enum logic [1:0] {
      ST_GROUNDED = 2'd0,
      ST_RISING   = 2'd1,
      ST_FALLING  = 2'd2
   } state_t;

   // Position maths is done in 11-bit signed so that X - step or Y + vy can
   // go past the limits (or below zero) without wrapping before the clamp.
   localparam logic signed [10:0] L_X_MIN     = 11'(X_MIN);
   localparam logic signed [10:0] L_X_MAX     = 11'(X_MAX);
   localparam logic signed [10:0] L_Y_MIN     = 11'(Y_MIN);
   localparam logic signed [10:0] L_Y_FLOOR   = 11'(Y_FLOOR);
   localparam logic signed [10:0] L_WALK_STEP = 11'(WALK_STEP);
   localparam logic signed [5:0]  L_JUMP_VEL  = 6'(JUMP_VEL);
   localparam logic signed [5:0]  L_GRAVITY   = 6'(GRAVITY);
   localparam logic signed [5:0]  L_MAX_FALL  = 6'(MAX_FALL);
   localparam logic [9:0]         L_X_START10 = 10'(X_START);
   localparam logic [9:0]         L_Y_START10 = 10'(Y_START);
   localparam logic [9:0]         L_Y_MIN10   = 10'(Y_MIN);
   localparam logic [9:0]         L_Y_FLOOR10 = 10'(Y_FLOOR);

   state_t             r_state;
   logic [9:0]         r_x;
   logic [9:0]         r_y;
   logic signed [5:0]  r_vy;
   logic               r_key_up_prev;
   logic               r_facing_left;
   logic               r_airborne;

   logic signed [10:0] w_x_s;
   logic signed [10:0] w_y_s;
   logic signed [10:0] w_x_left;
   logic signed [10:0] w_x_right;
   logic signed [10:0] w_x_left_clamped;
   logic signed [10:0] w_x_right_clamped;
   logic signed [10:0] w_vy_ext;
   logic signed [10:0] w_ny_rise;
   logic signed [5:0]  w_vy_inc;
   logic signed [5:0]  w_vy_fall;
   logic signed [10:0] w_vy_fall_ext;
   logic signed [10:0] w_ny_fall;
   logic               w_jump_req;
   logic               w_move_left;
   logic               w_move_right;

   assign w_x_s    = signed'({1'b0, r_x});
   assign w_y_s    = signed'({1'b0, r_y});

   assign w_x_left          = w_x_s - L_WALK_STEP;
   assign w_x_right         = w_x_s + L_WALK_STEP;
   assign w_x_left_clamped  = (w_x_left  < L_X_MIN) ? L_X_MIN : w_x_left;
   assign w_x_right_clamped = (w_x_right > L_X_MAX) ? L_X_MAX : w_x_right;
   assign w_move_left       = key_left & ~key_right;
   assign w_move_right      = key_right & ~key_left;

   assign w_vy_ext      = {{5{r_vy[5]}}, r_vy};
   assign w_ny_rise     = w_y_s + w_vy_ext;
   assign w_vy_inc      = r_vy + L_GRAVITY;
   assign w_vy_fall     = (w_vy_inc > L_MAX_FALL) ? L_MAX_FALL : w_vy_inc;
   assign w_vy_fall_ext = {{5{w_vy_fall[5]}}, w_vy_fall};
   assign w_ny_fall     = w_y_s + w_vy_fall_ext;

   // Rising edge of key_up across ticks; holding the key yields one jump.
   assign w_jump_req = key_up & ~r_key_up_prev;

   always_ff @(posedge vga_clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state       <= ST_GROUNDED;
         r_x           <= L_X_START10;
         r_y           <= L_Y_START10;
         r_vy          <= '0;
         // Treat key_up as already held so releasing reset never jumps.
         r_key_up_prev <= 1'b1;
         r_facing_left <= 1'b0;
         r_airborne    <= 1'b0;
      end else if (frame_start) begin
         r_key_up_prev <= key_up;

         if (w_move_left) begin
            r_x           <= w_x_left_clamped[9:0];
            r_facing_left <= 1'b1;
         end else if (w_move_right) begin
            r_x           <= w_x_right_clamped[9:0];
            r_facing_left <= 1'b0;
         end

         case (r_state)
            ST_GROUNDED: begin
               if (w_jump_req) begin
                  r_vy       <= -L_JUMP_VEL;
                  r_state    <= ST_RISING;
                  r_airborne <= 1'b1;
               end else if (!on_platform && (w_y_s < L_Y_FLOOR)) begin
                  // Walked off a ledge: start falling from rest.
                  r_vy       <= '0;
                  r_state    <= ST_FALLING;
                  r_airborne <= 1'b1;
               end
            end
            ST_RISING: begin
               if (w_ny_rise <= L_Y_MIN) begin
                  // Head bump against the ceiling.
                  r_y     <= L_Y_MIN10;
                  r_vy    <= '0;
                  r_state <= ST_FALLING;
               end else begin
                  r_y  <= w_ny_rise[9:0];
                  r_vy <= w_vy_inc;
                  if (!w_vy_inc[5]) begin
                     r_state <= ST_FALLING;
                  end
               end
            end
            ST_FALLING: begin
               if (on_platform) begin
                  r_vy       <= '0;
                  r_state    <= ST_GROUNDED;
                  r_airborne <= 1'b0;
               end else if (w_ny_fall >= L_Y_FLOOR) begin
                  r_y        <= L_Y_FLOOR10;
                  r_vy       <= '0;
                  r_state    <= ST_GROUNDED;
                  r_airborne <= 1'b0;
               end else begin
                  r_y  <= w_ny_fall[9:0];
                  r_vy <= w_vy_fall;
               end
            end
            default: begin
               r_state    <= ST_GROUNDED;
               r_airborne <= 1'b0;
            end
         endcase
      end
   end

   assign FireX       = r_x;
   assign FireY       = r_y;
   assign airborne    = r_airborne;
   assign facing_left = r_facing_left;

endmodule

// File: tb/tb_fireboy_motion.sv
// -----------------------------------------------------------------------------
// tb_fireboy_motion
// Drives two instances of fireboy_motion (default ceiling and Y_MIN=450) with
// the same per-frame stimulus. A behavioural model computes expected outputs
// at each tick; they are queued and popped once the DUT has registered them.
// -----------------------------------------------------------------------------
module tb_fireboy_motion;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       frame_start = 1'b0;
   logic       key_left = 1'b0;
   logic       key_right = 1'b0;
   logic       key_up = 1'b0;
   logic       on_platform = 1'b0;
   logic [9:0] fx0, fy0, fx1, fy1;
   logic       air0, air1, fl0, fl1;

   always #5 clk = ~clk;

   fireboy_motion u_dut0 (
      .vga_clk     (clk),
      .reset_n     (reset_n),
      .frame_start (frame_start),
      .key_left    (key_left),
      .key_right   (key_right),
      .key_up      (key_up),
      .on_platform (on_platform),
      .FireX       (fx0),
      .FireY       (fy0),
      .airborne    (air0),
      .facing_left (fl0)
   );

   fireboy_motion #(.Y_MIN(450)) u_dut1 (
      .vga_clk     (clk),
      .reset_n     (reset_n),
      .frame_start (frame_start),
      .key_left    (key_left),
      .key_right   (key_right),
      .key_up      (key_up),
      .on_platform (on_platform),
      .FireX       (fx1),
      .FireY       (fy1),
      .airborne    (air1),
      .facing_left (fl1)
   );

   typedef struct {
      int x0; int y0; int a0; int f0;
      int x1; int y1; int a1; int f1;
   } exp_t;

   exp_t sb_q[$];
   exp_t last_exp;

   int n_total = 0;
   int n_bad   = 0;
   int tick_no = 0;

   // Behavioural model state, one slot per instance.
   int mx[2], my[2], mvy[2], mst[2], mprev[2], mface[2];
   int ymin[2];

   // Expected jump trajectory from the floor (jump tick first, landing last).
   int traj[22] = '{464, 454, 445, 437, 430, 424, 419, 415, 412, 410, 409,
                    410, 412, 415, 419, 424, 430, 437, 445, 453, 461, 464};

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         mx[i] = 13; my[i] = 464; mvy[i] = 0; mst[i] = 0;
         mprev[i] = 1; mface[i] = 0;
      end
   endtask

   // States: 0 grounded, 1 rising, 2 falling.
   task automatic model_step(input int i, input int l, input int r, input int up, input int plat);
      int ny, v, jr;
      if (l != 0 && r == 0) begin
         mx[i] = (mx[i] - 2 < 13) ? 13 : mx[i] - 2;
         mface[i] = 1;
      end else if (r != 0 && l == 0) begin
         mx[i] = (mx[i] + 2 > 626) ? 626 : mx[i] + 2;
         mface[i] = 0;
      end
      jr = (up != 0 && mprev[i] == 0) ? 1 : 0;
      mprev[i] = up;
      if (mst[i] == 0) begin
         if (jr != 0) begin
            mvy[i] = -10; mst[i] = 1;
         end else if (plat == 0 && my[i] < 464) begin
            mvy[i] = 0; mst[i] = 2;
         end
      end else if (mst[i] == 1) begin
         ny = my[i] + mvy[i];
         if (ny <= ymin[i]) begin
            my[i] = ymin[i]; mvy[i] = 0; mst[i] = 2;
         end else begin
            my[i] = ny; mvy[i] = mvy[i] + 1;
            if (mvy[i] >= 0) mst[i] = 2;
         end
      end else begin
         if (plat != 0) begin
            mvy[i] = 0; mst[i] = 0;
         end else begin
            v  = (mvy[i] + 1 > 8) ? 8 : mvy[i] + 1;
            ny = my[i] + v;
            if (ny >= 464) begin
               my[i] = 464; mvy[i] = 0; mst[i] = 0;
            end else begin
               my[i] = ny; mvy[i] = v;
            end
         end
      end
   endtask

   task automatic check_outputs(input string tag, input exp_t e);
      chk({tag, "_x0"},  fx0,  e.x0);
      chk({tag, "_y0"},  fy0,  e.y0);
      chk({tag, "_air0"}, air0, e.a0);
      chk({tag, "_face0"}, fl0, e.f0);
      chk({tag, "_x1"},  fx1,  e.x1);
      chk({tag, "_y1"},  fy1,  e.y1);
      chk({tag, "_air1"}, air1, e.a1);
      chk({tag, "_face1"}, fl1, e.f1);
   endtask

   function automatic exp_t model_snapshot();
      exp_t e;
      e.x0 = mx[0]; e.y0 = my[0]; e.a0 = (mst[0] != 0) ? 1 : 0; e.f0 = mface[0];
      e.x1 = mx[1]; e.y1 = my[1]; e.a1 = (mst[1] != 0) ? 1 : 0; e.f1 = mface[1];
      return e;
   endfunction

   // One frame: a tick cycle followed by an idle cycle with scrambled inputs,
   // during which nothing may change.
   task automatic do_tick(input int l, input int r, input int up, input int plat);
      exp_t e;
      @(negedge clk);
      key_left    = l[0];
      key_right   = r[0];
      key_up      = up[0];
      on_platform = plat[0];
      frame_start = 1'b1;
      model_step(0, l, r, up, plat);
      model_step(1, l, r, up, plat);
      sb_q.push_back(model_snapshot());
      @(posedge clk);
      #1;
      frame_start = 1'b0;
      e = sb_q.pop_front();
      last_exp = e;
      check_outputs("tick", e);
      tick_no++;
      $display("tick %0d keys=%0b%0b%0b plat=%0b x=%0d y=%0d air=%0b face=%0b y1=%0d air1=%0b",
               tick_no, key_left, key_right, key_up, on_platform, fx0, fy0, air0, fl0, fy1, air1);
      @(negedge clk);
      key_left    = 1'($urandom_range(0, 1));
      key_right   = 1'($urandom_range(0, 1));
      key_up      = 1'($urandom_range(0, 1));
      on_platform = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
      check_outputs("hold", last_exp);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      exp_t rst_e;
      ymin[0] = 15;
      ymin[1] = 450;
      model_reset();
      rst_e = model_snapshot();

      // Reset state.
      reset_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_outputs("reset", rst_e);
      @(negedge clk);
      reset_n = 1'b1;

      // Idle on the floor.
      repeat (10) begin
         do_tick(0, 0, 0, 0);
         chk("idle_air", air0, 0);
      end

      // Walk right into the right wall.
      repeat (400) do_tick(0, 1, 0, 0);
      chk("walk_sat_x", fx0, 626);
      chk("walk_face", fl0, 0);

      // Both keys: nothing moves. Then one step left.
      repeat (5) do_tick(1, 1, 0, 0);
      chk("both_x", fx0, 626);
      do_tick(1, 0, 0, 0);
      chk("left_x", fx0, 624);
      chk("left_face", fl0, 1);

      // Single jump from the floor; second instance bumps its ceiling.
      for (int i = 0; i < 22; i++) begin
         do_tick(0, 0, (i == 0) ? 1 : 0, 0);
         chk("jump_y", fy0, traj[i]);
         chk("jump_air", air0, (i < 21) ? 1 : 0);
         if (i == 1) chk("ceil_y1_first", fy1, 454);
         if (i == 2) begin
            chk("ceil_y1_clamp", fy1, 450);
            chk("ceil_air1", air1, 1);
         end
      end

      // key_up held across landing: exactly one jump.
      for (int i = 0; i < 30; i++) do_tick(0, 0, 1, 0);
      chk("held_air", air0, 0);
      chk("held_y", fy0, 464);

      // Release for one tick, jump again, then land on a platform mid-fall.
      do_tick(0, 0, 0, 0);
      for (int i = 0; i < 13; i++) do_tick(0, 0, (i == 0) ? 1 : 0, 0);
      chk("rejump_y", fy0, traj[12]);
      chk("rejump_air", air0, 1);
      do_tick(0, 0, 0, 1);
      chk("plat_y", fy0, traj[12]);
      chk("plat_air", air0, 0);
      // Step off the platform and fall back to the floor.
      repeat (15) do_tick(0, 0, 0, 0);
      chk("refloor_y", fy0, 464);

      // Reset mid-jump between ticks.
      do_tick(1, 0, 1, 0);
      repeat (4) do_tick(0, 0, 0, 0);
      #3;
      reset_n = 1'b0;
      #1;
      model_reset();
      check_outputs("async_rst", rst_e);
      sb_q.delete();
      @(negedge clk);
      key_up = 1'b1;
      @(negedge clk);
      reset_n = 1'b1;
      // key_up already high at release: no jump.
      do_tick(0, 0, 1, 0);
      chk("post_rst_air", air0, 0);

      // Random frames.
      repeat (150) begin
         do_tick($urandom_range(0, 1), $urandom_range(0, 1),
                 $urandom_range(0, 1), ($urandom_range(0, 3) == 0) ? 1 : 0);
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

// File: doc/fireboy_motion.md
FIREBOY_MOTION -- requirements
Module: fireboy_motion

Interface
REQ-001 Parameters (name, default, meaning):
- X_START, 13, reset sprite-centre X
- Y_START, 464, reset sprite-centre Y
- X_MIN, 13, leftmost centre X
- X_MAX, 626, rightmost centre X
- Y_MIN, 15, topmost centre Y
- Y_FLOOR, 464, floor centre Y
- WALK_STEP, 2, pixels per frame horizontal
- JUMP_VEL, 10, initial upward speed
- GRAVITY, 1, per-frame velocity increment
- MAX_FALL, 8, terminal downward speed
REQ-002 Ports (name, direction, width, meaning):
- vga_clk, in, 1, sole clock; all state on posedge
- reset_n, in, 1, asynchronous active-low reset
- frame_start, in, 1, one-cycle pulse per video frame (start of vblank)
- key_left, in, 1, left key held; synchronous to vga_clk
- key_right, in, 1, right key held; synchronous to vga_clk
- key_up, in, 1, jump key held; synchronous to vga_clk
- on_platform, in, 1, level logic: feet rest on solid tile
- FireX, out, 10, sprite-centre X; feeds the sprite renderer
- FireY, out, 10, sprite-centre Y; feeds the sprite renderer
- airborne, out, 1, high in RISING or FALLING
- facing_left, out, 1, last horizontal direction was left

Function
REQ-003 All state updates occur only on vga_clk edges where frame_start=1 ("frame tick"); outputs hold between ticks.
REQ-004 Outputs are registered; new values appear the cycle after the tick.
REQ-005 Horizontal, on each tick:
- key_left=1 and key_right=0: X = max(X - WALK_STEP, X_MIN); facing_left=1.
- key_right=1 and key_left=0: X = min(X + WALK_STEP, X_MAX); facing_left=0.
- Both keys or neither: X and facing_left unchanged.
REQ-006 Vertical motion uses a 3-state FSM (GROUNDED, RISING, FALLING) and a signed 6-bit velocity vy, negative = up.
REQ-007 Position arithmetic is performed in 11-bit signed before clamping; no 10-bit wrap-around is permitted.
REQ-008 jump_req = key_up at this tick AND NOT key_up at the previous tick. key_up is registered on every tick regardless of state; holding key_up yields exactly one jump.
REQ-009 GROUNDED transitions:
- jump_req=1: vy = -JUMP_VEL, Y unchanged, go to RISING.
- Else if on_platform=0 and Y < Y_FLOOR: vy = 0, go to FALLING.
- Else: remain GROUNDED.
REQ-010 RISING, per tick: ny = Y + vy.
- ny <= Y_MIN: Y = Y_MIN, vy = 0, go to FALLING (head bump).
- Otherwise: Y = ny, vy = vy + GRAVITY.
- If the new vy >= 0: go to FALLING.
REQ-011 FALLING, per tick:
- on_platform=1: vy = 0, Y unchanged, go to GROUNDED.
- Otherwise: vy' = min(vy + GRAVITY, MAX_FALL), ny = Y + vy'.
- ny >= Y_FLOOR: Y = Y_FLOOR, vy = 0, go to GROUNDED.
- Otherwise: Y = ny, vy = vy'.
REQ-012 Horizontal and vertical updates apply in the same tick, independently.
REQ-013 airborne = (state != GROUNDED), registered with the state.

Reset
REQ-014 Asynchronous assertion, released synchronously:
- FireX=X_START, FireY=Y_START, vy=0, state GROUNDED
- airborne=0, facing_left=0, previous key_up=1 (no jump on reset release)
REQ-015 A reset asserted mid-jump returns the block to the REQ-014 values immediately, without waiting for a tick.

Verification
REQ-016 Reset, then 10 ticks with no keys -> FireX=13, FireY=464, airborne=0 throughout.
REQ-017 key_right held 400 ticks from reset -> FireX steps +2 per tick, saturates at 626, facing_left=0; key_left and key_right both held -> no change.
REQ-018 key_up pulsed at one tick from the floor -> jump tick FireY=464, airborne=1; subsequent FireY = 454, 445, 437, 430, 424, 419, 415, 412, 410, 409 (apex). Descent FireY = 410, 412, 415, 419, 424, 430, 437, 445, 453, 461, then 464 with airborne=0.
REQ-019 key_up held continuously across landing -> no second jump until key_up is released for at least one tick.
REQ-020 Set Y_MIN=450, then jump -> first tick FireY=454, second tick clamps to 450 and the FSM enters FALLING. Separately, on_platform=1 during FALLING -> FireY freezes and airborne=0 next cycle.
REQ-021 reset_n pulsed low mid-jump between ticks -> outputs return to 13/464/0/0 without waiting for frame_start.
